// File: rtl/gpu_pkg.sv
// Shared encodings for the core pipeline: the core FSM states and the fetch stage states.
package gpu_pkg;

    typedef enum logic [2:0] {
        CORE_IDLE    = 3'b000,
        CORE_FETCH   = 3'b001,
        CORE_DECODE  = 3'b010,
        CORE_REQUEST = 3'b011,
        CORE_WAIT    = 3'b100,
        CORE_EXECUTE = 3'b101,
        CORE_UPDATE  = 3'b110,
        CORE_DONE    = 3'b111
    } core_state_t;

    typedef enum logic [2:0] {
        FETCHER_IDLE     = 3'b000,
        FETCHER_FETCHING = 3'b001,
        FETCHER_FETCHED  = 3'b010
    } fetcher_state_t;

endpackage

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: combinational lookup, synchronous fill and flush.
module icache_dm #(
    parameter int CACHE_LINES = 8,
    parameter int ADDR_BITS   = 8,
    parameter int DATA_BITS   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_BITS-1:0] lookup_addr,
    output logic                 hit,
    output logic [DATA_BITS-1:0] rdata,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 flush
);
    localparam int IDX_BITS = $clog2(CACHE_LINES);
    localparam int TAG_BITS = ADDR_BITS - IDX_BITS;

    logic [CACHE_LINES-1:0] valid;
    logic [TAG_BITS-1:0]    tags [CACHE_LINES];
    logic [DATA_BITS-1:0]   data [CACHE_LINES];

    logic [IDX_BITS-1:0] lookup_idx;
    logic [IDX_BITS-1:0] wr_idx;

    assign lookup_idx = lookup_addr[IDX_BITS-1:0];
    assign wr_idx     = wr_addr[IDX_BITS-1:0];
    assign hit        = valid[lookup_idx] && (tags[lookup_idx] == lookup_addr[ADDR_BITS-1:IDX_BITS]);
    assign rdata      = data[lookup_idx];

    // Flush beats a coincident fill so a line written during invalidation never survives.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            tags[wr_idx] <= wr_addr[ADDR_BITS-1:IDX_BITS];
            data[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/instr_fetcher.sv
// Instruction fetch stage: cache lookup on FETCH, program-memory read on miss, holds result for DECODE.
//  state    | meaning
//  IDLE     | waiting for the core to enter FETCH
//  FETCHING | miss outstanding, request held until mem_read_ready
//  FETCHED  | instruction valid and stable until core reaches DECODE
module instr_fetcher
    import gpu_pkg::*;
#(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16,
    parameter int CACHE_LINES           = 8,
    parameter int CNT_BITS              = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    input  logic                             icache_invalidate,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
    output logic [CNT_BITS-1:0]              hit_count,
    output logic [CNT_BITS-1:0]              miss_count
);
    localparam logic [CNT_BITS-1:0] CNT_ONE = 1;

    fetcher_state_t state, state_next;
    logic                             valid_next;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] address_next;
    logic [PROGRAM_MEM_DATA_BITS-1:0] instruction_next;
    logic [CNT_BITS-1:0]              hit_next, miss_next;

    logic                             cache_hit;
    logic [PROGRAM_MEM_DATA_BITS-1:0] cache_rdata;
    logic                             fill;

    // Fill address comes from the held request so later PC changes cannot corrupt the line.
    assign fill          = (state == FETCHER_FETCHING) && mem_read_ready;
    assign fetcher_state = state;

    icache_dm #(
        .CACHE_LINES(CACHE_LINES),
        .ADDR_BITS  (PROGRAM_MEM_ADDR_BITS),
        .DATA_BITS  (PROGRAM_MEM_DATA_BITS)
    ) u_icache (
        .clk        (clk),
        .reset      (reset),
        .lookup_addr(current_pc),
        .hit        (cache_hit),
        .rdata      (cache_rdata),
        .wr_en      (fill),
        .wr_addr    (mem_read_address),
        .wr_data    (mem_read_data),
        .flush      (icache_invalidate)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= FETCHER_IDLE;
            mem_read_valid   <= 1'b0;
            mem_read_address <= '0;
            instruction      <= '0;
            hit_count        <= '0;
            miss_count       <= '0;
        end else begin
            state            <= state_next;
            mem_read_valid   <= valid_next;
            mem_read_address <= address_next;
            instruction      <= instruction_next;
            hit_count        <= hit_next;
            miss_count       <= miss_next;
        end
    end

    always_comb begin
        state_next       = state;
        valid_next       = mem_read_valid;
        address_next     = mem_read_address;
        instruction_next = instruction;
        hit_next         = hit_count;
        miss_next        = miss_count;
        case (state)
            FETCHER_IDLE: begin
                if (core_state == CORE_FETCH) begin
                    if (cache_hit) begin
                        instruction_next = cache_rdata;
                        state_next       = FETCHER_FETCHED;
                        hit_next         = (hit_count == '1) ? hit_count : hit_count + CNT_ONE;
                    end else begin
                        valid_next   = 1'b1;
                        address_next = current_pc;
                        state_next   = FETCHER_FETCHING;
                        miss_next    = (miss_count == '1) ? miss_count : miss_count + CNT_ONE;
                    end
                end
            end
            FETCHER_FETCHING: begin
                if (mem_read_ready) begin
                    instruction_next = mem_read_data;
                    valid_next       = 1'b0;
                    state_next       = FETCHER_FETCHED;
                end
            end
            FETCHER_FETCHED: begin
                if (core_state == CORE_DECODE) begin
                    state_next = FETCHER_IDLE;
                end
            end
            default: state_next = FETCHER_IDLE;
        endcase
    end

endmodule

// File: tb/tb_instr_fetcher.sv
// Bench for instr_fetcher: directed scenarios plus random traffic against a behavioural cache model.
module tb_instr_fetcher;
    localparam int AW    = 8;
    localparam int DW    = 16;
    localparam int LINES = 8;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    core_state;
    logic [AW-1:0] current_pc;
    logic          icache_invalidate;
    logic          mem_read_valid;
    logic [AW-1:0] mem_read_address;
    logic          mem_read_ready;
    logic [DW-1:0] mem_read_data;
    logic [2:0]    fetcher_state;
    logic [DW-1:0] instruction;
    logic [CW-1:0] hit_count;
    logic [CW-1:0] miss_count;

    always #5 clk = ~clk;

    instr_fetcher #(
        .PROGRAM_MEM_ADDR_BITS(AW),
        .PROGRAM_MEM_DATA_BITS(DW),
        .CACHE_LINES          (LINES),
        .CNT_BITS             (CW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .core_state       (core_state),
        .current_pc       (current_pc),
        .icache_invalidate(icache_invalidate),
        .mem_read_valid   (mem_read_valid),
        .mem_read_address (mem_read_address),
        .mem_read_ready   (mem_read_ready),
        .mem_read_data    (mem_read_data),
        .fetcher_state    (fetcher_state),
        .instruction      (instruction),
        .hit_count        (hit_count),
        .miss_count       (miss_count)
    );

    logic [DW-1:0] prog [256];
    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 0;

    // Behavioural model: phase 0 waiting, 1 memory read outstanding, 2 holding instruction.
    int            m_phase;
    logic          m_req;
    logic [AW-1:0] m_addr;
    logic [AW-1:0] m_fpc;
    logic [DW-1:0] m_instr;
    int            m_hits, m_misses;
    bit            m_valid [LINES];
    int            m_tag   [LINES];
    logic [DW-1:0] m_data  [LINES];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        int  idx;
        int  tg;
        bit  hit;
        if (reset) begin
            m_phase  = 0;
            m_req    = 0;
            m_addr   = '0;
            m_instr  = '0;
            m_hits   = 0;
            m_misses = 0;
            for (int i = 0; i < LINES; i++) m_valid[i] = 0;
        end else begin
            idx = int'(current_pc) % LINES;
            tg  = int'(current_pc) / LINES;
            hit = m_valid[idx] && (m_tag[idx] == tg);
            if (m_phase == 0) begin
                if (core_state == 3'b001) begin
                    m_fpc = current_pc;
                    if (hit) begin
                        m_instr = m_data[idx];
                        m_phase = 2;
                        if (m_hits < CMAX) m_hits++;
                    end else begin
                        m_req   = 1;
                        m_addr  = current_pc;
                        m_phase = 1;
                        if (m_misses < CMAX) m_misses++;
                    end
                end
            end else if (m_phase == 1) begin
                if (mem_read_ready) begin
                    m_instr = mem_read_data;
                    m_valid[int'(m_addr) % LINES] = 1;
                    m_tag[int'(m_addr) % LINES]   = int'(m_addr) / LINES;
                    m_data[int'(m_addr) % LINES]  = mem_read_data;
                    m_req   = 0;
                    m_phase = 2;
                end
            end else if (core_state == 3'b010) begin
                m_phase = 0;
            end
            if (icache_invalidate) for (int i = 0; i < LINES; i++) m_valid[i] = 0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("fetcher_state", 32'(fetcher_state), 32'(m_phase));
            check("mem_read_valid", 32'(mem_read_valid), 32'(m_req));
            check("mem_read_address", 32'(mem_read_address), 32'(m_addr));
            check("instruction", 32'(instruction), 32'(m_instr));
            check("hit_count", 32'(hit_count), 32'(m_hits));
            check("miss_count", 32'(miss_count), 32'(m_misses));
            if (m_phase == 2) check("instr_vs_program", 32'(instruction), 32'(prog[m_fpc]));
        end
    end

    task automatic do_fetch(input logic [AW-1:0] pc, input int wait_n, input bit inval_on_ready,
                            output int vcyc, output int lat);
        int w;
        bit done;
        vcyc = 0; lat = 0; w = 0; done = 0;
        current_pc = pc;
        core_state = 3'b001;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk);
            lat++;
            mem_read_ready    = 1'b0;
            icache_invalidate = 1'b0;
            if (mem_read_valid) vcyc++;
            if (m_phase == 2) done = 1;
            else if (m_phase == 1) begin
                if (w == wait_n) begin
                    mem_read_ready    = 1'b1;
                    mem_read_data     = prog[m_addr];
                    icache_invalidate = inval_on_ready;
                end else w++;
            end
        end
        if (!done) check("fetch_timeout", 32'd0, 32'd1);
    endtask

    task automatic release_decode();
        core_state = 3'b010;
        @(negedge clk);
        core_state = 3'b000;
    endtask

    initial begin
        int vc, lt;
        logic [DW-1:0] pinned;
        reset = 1'b1; core_state = 3'b000; current_pc = '0; icache_invalidate = 1'b0;
        mem_read_ready = 1'b0; mem_read_data = '0;
        for (int i = 0; i < 256; i++) prog[i] = DW'($urandom);
        prog[8'h05] = 16'h3A17;
        prog[8'h0D] = 16'h7001;
        @(negedge clk);
        @(negedge clk);
        cmp_en = 1;
        check("reset_state", 32'(fetcher_state), 32'h0);
        check("reset_valid", 32'(mem_read_valid), 32'h0);
        check("reset_instr", 32'(instruction), 32'h0);
        check("reset_counts", 32'({hit_count, miss_count}), 32'h0);
        reset = 1'b0;

        // cold miss
        do_fetch(8'h05, 3, 0, vc, lt);
        check("cold_valid_cycles", 32'(vc), 32'd4);
        check("cold_instr", 32'(instruction), 32'h3A17);
        check("cold_state", 32'(fetcher_state), 32'h2);
        check("cold_miss_count", 32'(miss_count), 32'd1);
        check("model_pin_instr", 32'(m_instr), 32'h3A17);
        release_decode();

        // hit
        do_fetch(8'h05, 0, 0, vc, lt);
        check("hit_valid_cycles", 32'(vc), 32'd0);
        check("hit_latency", 32'(lt), 32'd1);
        check("hit_instr", 32'(instruction), 32'h3A17);
        check("hit_count", 32'(hit_count), 32'd1);
        release_decode();

        // conflict on index 5
        do_fetch(8'h0D, 1, 0, vc, lt);
        check("conflict_a_miss", 32'(vc), 32'd2);
        check("conflict_a_instr", 32'(instruction), 32'h7001);
        release_decode();
        do_fetch(8'h05, 2, 0, vc, lt);
        check("conflict_b_miss", 32'(vc), 32'd3);
        check("conflict_b_instr", 32'(instruction), 32'h3A17);
        check("conflict_miss_count", 32'(miss_count), 32'd3);
        release_decode();

        // invalidate coincident with fill
        pinned = prog[8'h02];
        do_fetch(8'h02, 0, 1, vc, lt);
        check("race_instr", 32'(instruction), 32'(pinned));
        check("race_state", 32'(fetcher_state), 32'h2);
        release_decode();
        do_fetch(8'h02, 0, 0, vc, lt);
        check("race_refetch_misses", 32'(vc), 32'd1);
        check("race_miss_count", 32'(miss_count), 32'd5);
        release_decode();

        // reset mid-fetch, then a late ready
        current_pc = 8'h10; core_state = 3'b001;
        @(negedge clk);
        core_state = 3'b000;
        check("midfetch_valid", 32'(mem_read_valid), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_valid_dropped", 32'(mem_read_valid), 32'd0);
        reset = 1'b0;
        mem_read_ready = 1'b1; mem_read_data = 16'hBEEF;
        @(negedge clk);
        mem_read_ready = 1'b0;
        @(negedge clk);
        check("rst_state", 32'(fetcher_state), 32'h0);
        check("rst_instr", 32'(instruction), 32'h0);
        check("rst_counts", 32'({hit_count, miss_count}), 32'h0);

        // saturation of the hit counter
        do_fetch(8'h05, 0, 0, vc, lt);
        release_decode();
        for (int i = 0; i < 17; i++) begin
            do_fetch(8'h05, 0, 0, vc, lt);
            release_decode();
        end
        check("sat_hit_count", 32'(hit_count), 32'hF);
        check("sat_miss_count", 32'(miss_count), 32'd1);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            int r;
            @(negedge clk);
            reset = ($urandom_range(0, 299) == 0);
            r = $urandom_range(0, 9);
            if (r < 5) core_state = 3'b001;
            else if (r < 8) core_state = 3'b010;
            else core_state = 3'($urandom);
            current_pc = AW'($urandom_range(0, 31));
            icache_invalidate = ($urandom_range(0, 39) == 0);
            if (m_phase == 1 && $urandom_range(0, 2) == 0) begin
                mem_read_ready = 1'b1;
                mem_read_data  = prog[m_addr];
            end else if (m_phase != 1 && $urandom_range(0, 7) == 0) begin
                mem_read_ready = 1'b1;
                mem_read_data  = DW'($urandom);
            end else begin
                mem_read_ready = 1'b0;
            end
        end
        @(negedge clk);
        cmp_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
